// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a word and its parity bit, then walks
// the TX mux through start, data, optional parity and stop while pacing the serializer.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_DONE,
  output logic                  ser_EN,
  output logic [DATA_WIDTH-1:0] ser_P_DATA,
  output logic [1:0]            mux_sel,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DATA_WIDTH + 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_DATA   = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                       input logic                  odd);
    return (^data) ^ odd;
  endfunction

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   ser_p_data_q, ser_p_data_d;
  logic                    par_bit_q, par_bit_d;
  logic                    par_en_q, par_en_d;
  logic [1:0]              mux_sel_q, mux_sel_d;
  logic                    busy_q, busy_d;
  logic                    ser_en_q, ser_en_d;
  logic                    latch_s;

  // Next-state logic, data-cycle watchdog and latch request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (DATA_VALID) begin
          latch_s = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = CNT_ZERO;
      end
      ST_DATA: begin
        if (ser_DONE) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TMO_LAST) begin
          // Serializer never reported completion: close the frame without parity.
          state_d = ST_STOP;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_DATA;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP;
      end
      ST_STOP: begin
        if (DATA_VALID) begin
          latch_s = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Moore output decode of the upcoming state, so the output flops track the state register.
  always_comb begin
    mux_sel_d = MUX_STOP;
    busy_d    = 1'b0;
    ser_en_d  = 1'b0;
    case (state_d)
      ST_IDLE: begin
        mux_sel_d = MUX_STOP;
        busy_d    = 1'b0;
        ser_en_d  = 1'b0;
      end
      ST_START: begin
        mux_sel_d = MUX_START;
        busy_d    = 1'b1;
        ser_en_d  = 1'b1;
      end
      ST_DATA: begin
        mux_sel_d = MUX_DATA;
        busy_d    = 1'b1;
        ser_en_d  = 1'b1;
      end
      ST_PARITY: begin
        mux_sel_d = MUX_PARITY;
        busy_d    = 1'b1;
        ser_en_d  = 1'b0;
      end
      ST_STOP: begin
        mux_sel_d = MUX_STOP;
        busy_d    = 1'b1;
        ser_en_d  = 1'b0;
      end
      default: begin
        mux_sel_d = MUX_STOP;
        busy_d    = 1'b0;
        ser_en_d  = 1'b0;
      end
    endcase
  end

  // Frame parameters captured once per frame; later input changes are ignored.
  always_comb begin
    if (latch_s) begin
      ser_p_data_d = P_DATA;
      par_bit_d    = calc_parity(P_DATA, PAR_TYP);
      par_en_d     = PAR_EN;
    end else begin
      ser_p_data_d = ser_p_data_q;
      par_bit_d    = par_bit_q;
      par_en_d     = par_en_q;
    end
  end

  // State, watchdog, frame data and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      ser_p_data_q <= {DATA_WIDTH{1'b0}};
      par_bit_q    <= 1'b0;
      par_en_q     <= 1'b0;
      mux_sel_q    <= MUX_STOP;
      busy_q       <= 1'b0;
      ser_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ser_p_data_q <= ser_p_data_d;
      par_bit_q    <= par_bit_d;
      par_en_q     <= par_en_d;
      mux_sel_q    <= mux_sel_d;
      busy_q       <= busy_d;
      ser_en_q     <= ser_en_d;
    end
  end

  assign ser_EN     = ser_en_q;
  assign ser_P_DATA = ser_p_data_q;
  assign mux_sel    = mux_sel_q;
  assign par_bit    = par_bit_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level expected-output queue plus
// a small serializer model, with literal line sequences pinning each scenario.
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          ser_done;
  logic          ser_en;
  logic [DW-1:0] ser_p_data;
  logic [1:0]    mux_sel;
  logic          par_bit;
  logic          busy;

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .P_DATA(p_data), .DATA_VALID(data_valid),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .ser_DONE(ser_done),
    .ser_EN(ser_en), .ser_P_DATA(ser_p_data), .mux_sel(mux_sel),
    .par_bit(par_bit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Serializer stand-in: registers bit[n] on each enabled edge, flags the last bit.
  logic [3:0] s_cnt;
  logic       s_out;
  logic       ser_stuck;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt <= 4'd0;
      s_out <= 1'b0;
    end else if (ser_en) begin
      if (s_cnt < 4'd8) begin
        s_out <= ser_p_data[s_cnt[2:0]];
        s_cnt <= s_cnt + 4'd1;
      end
    end else begin
      s_cnt <= 4'd0;
    end
  end
  assign ser_done = !ser_stuck && (s_cnt == 4'd8);

  logic tx_line;
  always_comb begin
    case (mux_sel)
      2'b00:   tx_line = 1'b0;
      2'b01:   tx_line = s_out;
      2'b10:   tx_line = par_bit;
      default: tx_line = 1'b1;
    endcase
  end

  typedef struct packed {
    logic [1:0] mux;
    logic       line;
    logic       line_chk;
    logic       busy;
    logic       en;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_word;
  logic          m_par;
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   hist;
  int            busy_cnt;
  int            en_cnt;
  logic          par_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One accepted frame expands to its cycle-by-cycle line contents.
  task automatic push_frame(input logic [DW-1:0] w, input logic pe, input logic pt,
                            input logic stuck);
    exp_q.push_back('{2'b00, 1'b0, 1'b1, 1'b1, 1'b1});
    if (stuck) begin
      for (int i = 0; i < DW + 2; i++) exp_q.push_back('{2'b01, 1'b0, 1'b0, 1'b1, 1'b1});
    end else begin
      for (int i = 0; i < DW; i++) exp_q.push_back('{2'b01, w[i], 1'b1, 1'b1, 1'b1});
      if (pe) exp_q.push_back('{2'b10, (^w) ^ pt, 1'b1, 1'b1, 1'b0});
    end
    exp_q.push_back('{2'b11, 1'b1, 1'b1, 1'b1, 1'b0});
    m_word = w;
    m_par  = (^w) ^ pt;
  endtask

  task automatic compare_loop();
    exp_t e;
    logic at_end;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        m_word = '0;
        m_par  = 1'b0;
      end else begin
        if (exp_q.size() == 0) begin
          e      = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0};
          at_end = 1'b1;
        end else begin
          e      = exp_q.pop_front();
          at_end = (exp_q.size() == 0);
        end
        check("mux_sel", {30'd0, mux_sel}, {30'd0, e.mux});
        check("busy", {31'd0, busy}, {31'd0, e.busy});
        check("ser_EN", {31'd0, ser_en}, {31'd0, e.en});
        if (e.line_chk) check("tx_line", {31'd0, tx_line}, {31'd0, e.line});
        check("ser_P_DATA", {24'd0, ser_p_data}, {24'd0, m_word});
        check("par_bit", {31'd0, par_bit}, {31'd0, m_par});
        if (busy) begin
          hist = {hist[30:0], tx_line};
          busy_cnt++;
        end
        if (ser_en) en_cnt++;
        if (mux_sel == 2'b10) par_seen = 1'b1;
        if (data_valid && at_end) push_frame(p_data, par_en, par_typ, ser_stuck);
      end
    end
  endtask

  task automatic clr_hist();
    hist     = 32'd0;
    busy_cnt = 0;
    en_cnt   = 0;
    par_seen = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input logic pe, input logic pt);
    p_data     = w;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    cycles(1);
    data_valid = 1'b0;
    p_data     = ~w;
    par_en     = ~pe;
    par_typ    = ~pt;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_mux"}, {30'd0, mux_sel}, 32'd3);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_en"}, {31'd0, ser_en}, 32'd0);
    check({tag, "_pdata"}, {24'd0, ser_p_data}, 32'd0);
    check({tag, "_par"}, {31'd0, par_bit}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    p_data     = 8'h00;
    data_valid = 1'b0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    ser_stuck  = 1'b0;
    clr_hist();
    fork
      compare_loop();
    join_none
    #1;
    reset_checks("por");
    cycles(2);
    rst = 1'b0;
    cycles(2);

    clr_hist();
    send(8'hA5, 1'b1, 1'b0);
    cycles(13);
    check("even_line", {21'd0, hist[10:0]}, {21'd0, 11'b01010010101});
    check("even_busy_cycles", busy_cnt, 32'd11);
    check("even_en_cycles", en_cnt, 32'd9);
    check("even_par_bit", {31'd0, par_bit}, 32'd0);

    clr_hist();
    send(8'hA5, 1'b1, 1'b1);
    cycles(13);
    check("odd_line", {21'd0, hist[10:0]}, {21'd0, 11'b01010010111});
    check("odd_par_bit", {31'd0, par_bit}, 32'd1);

    clr_hist();
    send(8'h3C, 1'b0, 1'b0);
    cycles(12);
    check("nopar_line", {22'd0, hist[9:0]}, {22'd0, 10'b0001111001});
    check("nopar_busy_cycles", busy_cnt, 32'd10);
    check("nopar_par_seen", {31'd0, par_seen}, 32'd0);

    clr_hist();
    p_data     = 8'hFF;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    data_valid = 1'b1;
    cycles(1);
    p_data = 8'h01;
    cycles(11);
    data_valid = 1'b0;
    cycles(13);
    check("b2b_line", {10'd0, hist[21:0]}, {10'd0, 22'b0111111110101000000011});
    check("b2b_busy_cycles", busy_cnt, 32'd22);
    check("b2b_en_cycles", en_cnt, 32'd18);

    clr_hist();
    send(8'h5A, 1'b1, 1'b0);
    cycles(2);
    p_data     = 8'hC3;
    data_valid = 1'b1;
    cycles(1);
    data_valid = 1'b0;
    cycles(2);
    p_data     = 8'h0F;
    data_valid = 1'b1;
    cycles(1);
    data_valid = 1'b0;
    cycles(12);
    check("midchg_line", {21'd0, hist[10:0]}, {21'd0, 11'b00101101001});
    check("midchg_busy_cycles", busy_cnt, 32'd11);

    clr_hist();
    ser_stuck = 1'b1;
    send(8'hA5, 1'b1, 1'b0);
    cycles(15);
    ser_stuck = 1'b0;
    check("tmo_busy_cycles", busy_cnt, 32'd12);
    check("tmo_en_cycles", en_cnt, 32'd11);
    check("tmo_par_seen", {31'd0, par_seen}, 32'd0);
    check("tmo_stop_bit", {31'd0, hist[0]}, 32'd1);
    check("tmo_idle_busy", {31'd0, busy}, 32'd0);

    @(posedge clk);
    #3 rst = 1'b1;
    #1 reset_checks("rst_idle");
    cycles(1);
    rst = 1'b0;
    cycles(2);

    send(8'h3C, 1'b0, 1'b0);
    cycles(3);
    #2 rst = 1'b1;
    #1 reset_checks("rst_data");
    cycles(1);
    rst = 1'b0;
    cycles(3);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmit path. It accepts a parallel byte with a valid strobe, latches the byte and its parity bit, and sequences the bit serializer. It drives the TX output mux select in the order start, data, parity (optional), stop. The block sits between the host interface and the serializer/mux, and owns the busy indication for the TX path.

Parameters:
DATA_WIDTH, 8, width of the transmitted data word; the serializer is built with the same value.

Ports:
clk  input  1  transmit bit clock; one UART bit per clk cycle.
rst  input  1  asynchronous, active-high reset.
P_DATA  input  DATA_WIDTH  parallel word to transmit.
DATA_VALID  input  1  request strobe; P_DATA is valid in the same cycle.
PAR_EN  input  1  1 = insert parity bit; sampled at latch.
PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled at latch.
ser_DONE  input  1  serializer completion flag; combinational, high in the cycle the last data bit is on the line.
ser_EN  output  1  serializer enable.
ser_P_DATA  output  DATA_WIDTH  latched word presented to the serializer.
mux_sel  output  2  TX mux select: 00 start (0), 01 serial data, 10 parity, 11 stop/idle (1).
par_bit  output  1  latched parity bit for the mux.
busy  output  1  high while a frame is in progress.

Behaviour:
- Reset:
  - state=IDLE, mux_sel=11, ser_EN=0, busy=0, ser_P_DATA=0, par_bit=0.
  - Reset asserted mid-frame aborts immediately; the line returns to 1 (mux_sel=11) asynchronously.
- Output decoding:
  - ser_EN, mux_sel and busy are Moore outputs decoded from the state register only.
  - ser_P_DATA and par_bit are registers.
- Latch event (IDLE or STOP with DATA_VALID=1):
  - ser_P_DATA<=P_DATA.
  - par_bit<=(^P_DATA)^PAR_TYP.
  - par_en_q<=PAR_EN.
- States:
  - IDLE: mux_sel=11, busy=0, ser_EN=0. DATA_VALID=1 -> latch event, go to START.
  - START: mux_sel=00, busy=1, ser_EN=1. Lasts 1 cycle, then go to DATA. ser_EN is pre-asserted so serializer bit 0 is registered on its output at the first DATA cycle.
  - DATA: mux_sel=01, busy=1, ser_EN=1. Stay until ser_DONE=1, which occurs in the DATA_WIDTH-th DATA cycle. On ser_DONE, go to PARITY if par_en_q=1, else STOP.
  - PARITY: mux_sel=10, busy=1, ser_EN=0. Lasts 1 cycle, then go to STOP.
  - STOP: mux_sel=11, busy=1, ser_EN=0. Lasts 1 cycle. If DATA_VALID=1 in this cycle: latch event, go to START (back-to-back frame, no idle bit). Otherwise go to IDLE.
- DATA_VALID is ignored in START, DATA and PARITY. No queuing; the requester must hold or re-present the word.
- P_DATA, PAR_EN and PAR_TYP changes after the latch event do not affect the frame in flight.
- Latency: DATA_VALID sampled at edge N puts the start bit on the line in cycle N+1.
- Frame length is 1+DATA_WIDTH+1 cycles without parity, or +1 with parity (10 or 11 for DATA_WIDTH=8).
- Timeout guard: if DATA lasts DATA_WIDTH+2 cycles without ser_DONE, go to STOP. The frame completes with a stop bit and no parity; no hang.
- ser_EN drops to 0 in the cycle after ser_DONE, so the serializer counter is at 0 for the next frame.
- Any undefined state encoding recovers to IDLE.

Test Plan:
- Reset check: assert rst mid-idle and mid-DATA -> mux_sel=11, busy=0, ser_EN=0, ser_P_DATA=0 immediately, without waiting for a clk edge.
- Even parity frame: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID -> line sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop). busy high exactly 11 cycles; ser_EN high 9 cycles (START plus 8 DATA).
- Odd parity frame: same word, PAR_TYP=1 -> parity bit 1. No-parity frame, P_DATA=8'h3C, PAR_EN=0 -> 10-cycle frame 0,0,0,1,1,1,1,0,0,1 with mux_sel never 10.
- Back-to-back: DATA_VALID with 8'h01 held high during the STOP of the previous frame (8'hFF) -> the next start bit follows the stop bit directly, and busy stays high across the frame boundary.
- Mid-frame changes: P_DATA changes and DATA_VALID pulses during DATA -> transmitted bits match the originally latched word, and no second frame starts.
- Timeout: model ser_DONE stuck at 0 -> FSM leaves DATA after 10 cycles, emits stop, then returns to IDLE with busy=0.
